// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store initiator.
// Imported by lsu_master and lsu_extend.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  localparam logic [3:0] MEM_SZ_BYTE = 4'd1;
  localparam logic [3:0] MEM_SZ_HALF = 4'd2;

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: byte loads get a zero or sign-filled
// upper byte, halfwords pass through untouched.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] result,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = result;
    if (size == SZ_BYTE) begin
      rdata = {{(DATA_W-8){sgn & result[7]}}, result[7:0]};
    end
  end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator for datamem: one request at a time,
// misaligned halfwords split into two byte accesses.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_xfer_size,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e state, state_next;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] result;
  logic              r_error;

  logic              accept;
  logic              illegal;
  logic              half;
  logic              split;
  logic [DATA_W-1:0] ext_data;

  assign accept  = req_valid && req_ready;
  // a halfword at the top address would wrap on its second byte
  assign illegal = req_size[1] ||
                   (req_size == SZ_HALF && req_addr == '1);
  assign half    = r_size == SZ_HALF;
  assign split   = half && r_addr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      r_write  <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      result   <= '0;
      r_error  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        result   <= '0;
        r_error  <= illegal;
      end
      if (state == ACC0 && !r_write) begin
        if (half && !split) begin
          result <= mem_read_data;
        end else begin
          result[7:0] <= mem_read_data[7:0];
        end
      end
      if (state == ACC1 && !r_write) begin
        result[15:8] <= mem_read_data[7:0];
      end
    end
  end

  always_comb begin
    state_next       = state;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = '0;
    mem_xfer_size    = MEM_SZ_BYTE;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = illegal ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_address      = r_addr;
        mem_write_enable = r_write && !reset;
        mem_read_enable  = !r_write && !reset;
        if (half && !split) begin
          mem_xfer_size  = MEM_SZ_HALF;
          mem_write_data = r_wdata;
        end else begin
          mem_write_data = {{(DATA_W-8){1'b0}}, r_wdata[7:0]};
        end
        state_next = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_address      = r_addr + ADDR_W'(1);
        mem_write_enable = r_write && !reset;
        mem_read_enable  = !r_write && !reset;
        mem_write_data   = {{(DATA_W-8){1'b0}}, r_wdata[15:8]};
        state_next       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  lsu_extend #(
    .DATA_W(DATA_W)
  ) u_extend (
    .result(result),
    .size  (r_size),
    .sgn   (r_signed),
    .rdata (ext_data)
  );

  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = (state == RESP) ? ext_data : '0;
  assign rsp_error = (state == RESP) && r_error;

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master with a byte-array datamem model
// and a response scoreboard.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic [15:0] mem_address;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [15:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [15:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_master dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .mem_address     (mem_address),
    .mem_write_enable(mem_write_enable),
    .mem_read_enable (mem_read_enable),
    .mem_write_data  (mem_write_data),
    .mem_xfer_size   (mem_xfer_size),
    .mem_read_data   (mem_read_data)
  );

  // datamem model; undefined upper byte on byte reads is junk
  bit   [7:0]  mem [0:65535];
  logic [15:0] wl_addr [0:31];
  logic [3:0]  wl_size [0:31];
  logic [15:0] wl_data [0:31];
  int          wcount = 0;
  int          en_count = 0;

  always_comb begin
    mem_read_data = {8'hA5, mem[mem_address]};
    if (mem_xfer_size == 4'd2) begin
      mem_read_data = {mem[mem_address + 16'd1], mem[mem_address]};
    end
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data[7:0];
      if (mem_xfer_size == 4'd2) begin
        mem[mem_address + 16'd1] <= mem_write_data[15:8];
      end
      if (wcount < 32) begin
        wl_addr[wcount] <= mem_address;
        wl_size[wcount] <= mem_xfer_size;
        wl_data[wcount] <= mem_write_data;
      end
      wcount <= wcount + 1;
    end
    if (mem_write_enable || mem_read_enable) begin
      en_count <= en_count + 1;
    end
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic w,
                        input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] er, input logic ee,
                        input int el, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    int   guard;
    sb.push_back('{rdata: er, err: ee, lat: el});
    guard = 0;
    while (!req_ready && guard < 10) begin
      step();
      guard++;
    end
    check({tag, "_rdy"}, req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    e = sb.pop_front();
    got = '{rdata: rsp_rdata, err: rsp_error, lat: lat};
    check({tag, "_lat"}, got.lat, e.lat);
    check({tag, "_rdata"}, got.rdata, e.rdata);
    check({tag, "_err"}, got.err, e.err);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_v"}, rsp_valid, 1'b1);
      check({tag, "_hold_d"}, rsp_rdata, e.rdata);
      check({tag, "_hold_rdy"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    check({tag, "_rdy_pre"}, req_ready, 1'b0);
    step();
    rsp_ready = 1'b0;
    check({tag, "_drop_v"}, rsp_valid, 1'b0);
    check({tag, "_idle"}, req_ready, 1'b1);
  endtask

  task automatic check_wr(input string tag, input int idx,
                          input logic [15:0] a, input logic [3:0] sz,
                          input logic [15:0] d);
    check({tag, "_waddr"}, wl_addr[idx], a);
    check({tag, "_wsize"}, wl_size[idx], sz);
    check({tag, "_wdata"}, wl_data[idx], d);
  endtask

  initial begin
    int w0;
    int e0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = 16'h0;
    rsp_ready  = 1'b0;
    step();
    step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_we", mem_write_enable, 1'b0);
    check("rst_re", mem_read_enable, 1'b0);
    check("rst_addr", mem_address, 16'h0);
    check("rst_wdata", mem_write_data, 16'h0);
    check("rst_xfer", mem_xfer_size, 4'd1);
    reset = 1'b0;
    step();

    w0 = wcount;
    do_req("st_beef", 1, 2'd1, 0, 16'h0010, 16'hBEEF, 16'h0, 0, 2, 0);
    check("st_beef_nw", wcount - w0, 1);
    check_wr("st_beef", w0, 16'h0010, 4'd2, 16'hBEEF);
    do_req("ldsb_11", 0, 2'd0, 1, 16'h0011, 16'h0, 16'hFFBE, 0, 2, 0);
    do_req("ldh_10", 0, 2'd1, 0, 16'h0010, 16'h0, 16'hBEEF, 0, 2, 0);

    w0 = wcount;
    do_req("st_1234", 1, 2'd1, 0, 16'h0021, 16'h1234, 16'h0, 0, 3, 0);
    check("st_1234_nw", wcount - w0, 2);
    check_wr("st_1234_a", w0, 16'h0021, 4'd1, 16'h0034);
    check_wr("st_1234_b", w0 + 1, 16'h0022, 4'd1, 16'h0012);
    do_req("ldh_21", 0, 2'd1, 1, 16'h0021, 16'h0, 16'h1234, 0, 3, 0);
    do_req("ldub_22", 0, 2'd0, 0, 16'h0022, 16'h0, 16'h0012, 0, 2, 0);

    e0 = en_count;
    do_req("err_ffff", 0, 2'd1, 0, 16'hFFFF, 16'h0, 16'h0, 1, 1, 0);
    do_req("err_sz3", 1, 2'd3, 0, 16'h0040, 16'hFFFF, 16'h0, 1, 1, 0);
    do_req("err_sz2", 0, 2'd2, 1, 16'h0041, 16'h0, 16'h0, 1, 1, 0);
    check("err_no_en", en_count - e0, 0);

    do_req("stb_80", 1, 2'd0, 0, 16'h0040, 16'h7F80, 16'h0, 0, 2, 0);
    check("stb_80_mem41", mem[16'h0041], 8'h00);
    do_req("ldub_40", 0, 2'd0, 0, 16'h0040, 16'h0, 16'h0080, 0, 2, 4);
    do_req("ldsb_40", 0, 2'd0, 1, 16'h0040, 16'h0, 16'hFF80, 0, 2, 4);

    do_req("stb_55", 1, 2'd0, 0, 16'h0032, 16'h0055, 16'h0, 0, 2, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd1;
    req_addr  = 16'h0031;
    req_wdata = 16'hAAAA;
    step();
    req_valid = 1'b0;
    check("rst_acc0_we", mem_write_enable, 1'b1);
    step();
    check("rst_acc1_addr", mem_address, 16'h0032);
    reset = 1'b1;
    #1;
    check("rst_acc1_we", mem_write_enable, 1'b0);
    step();
    reset = 1'b0;
    check("rst_mid_ready", req_ready, 1'b1);
    check("rst_mid_valid", rsp_valid, 1'b0);
    check("rst_mid_we", mem_write_enable, 1'b0);
    check("rst_mid_re", mem_read_enable, 1'b0);
    check("rst_mid_m31", mem[16'h0031], 8'hAA);
    check("rst_mid_m32", mem[16'h0032], 8'h55);
    do_req("ldub_31", 0, 2'd0, 0, 16'h0031, 16'h0, 16'h00AA, 0, 2, 0);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator that drives the datamem port (16-bit address and data, little-endian, aligned accesses only) for the core pipeline.
- Accepts one byte or halfword request at a time over a valid/ready handshake.
- Splits misaligned halfwords into two aligned byte accesses.
- Zero- or sign-extends read data and returns it over a valid/ready response channel.

Parameters:
- ADDR_W, 16, address width; must match datamem.
- DATA_W, 16, data width; must match datamem.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 and 3 are illegal.
- req_signed  in  1  sign-extend load data (ignored on stores and halfwords).
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; a byte store uses bits [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  16  load result; 0 for stores and errors.
- rsp_error  out  1  request was illegal; no memory access was made.
- mem_address  out  16  to datamem address.
- mem_write_enable  out  1  to datamem write_enable.
- mem_read_enable  out  1  to datamem read_enable.
- mem_write_data  out  16  to datamem write_data.
- mem_xfer_size  out  4  to datamem xfer_size; always 1 or 2.
- mem_read_data  in  16  from datamem read_data. Combinational read; only the bytes covered by the size are defined.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Reset or power-up enters IDLE.
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_error=0, mem enables=0, mem_address=0, mem_write_data=0, mem_xfer_size=1.
- Whenever no access is in progress, the mem outputs hold these values, so datamem never sees X.
- Accept: on a rising edge with req_valid && req_ready, latch the request. Next state:
  - ACC0 if the request is legal;
  - RESP with error=1 if it is illegal.
- Illegal requests: req_size >= 2, or halfword at 0xFFFF (split would wrap; datamem bounds check).
- ACC0, aligned access (byte, or halfword with addr[0]=0):
  - drive address = addr, size = 1 or 2, matching enable;
  - for halfword stores, write_data = wdata; for byte stores, write_data = {8'h00, wdata[7:0]};
  - a load registers mem_read_data at end of cycle;
  - next state RESP.
- ACC0, misaligned halfword (addr[0]=1): byte access at addr carrying wdata[7:0]; a load captures read[7:0] into result[7:0]. Next state ACC1.
- ACC1: byte access at addr+1 carrying wdata[15:8]; a load captures read[7:0] into result[15:8]. Next state RESP.
- Extension on byte loads: upper byte is {8{read[7]}} if req_signed, else 8'h00. Undefined upper bits from datamem never reach rsp_rdata.
- RESP: rsp_valid=1, rsp_rdata and rsp_error held stable until rsp_ready. Then next state IDLE and rsp_valid drops.
- Latency from accept edge to rsp_valid:
  - aligned: 2 cycles;
  - split: 3 cycles;
  - error: 1 cycle.
- Throughput: one request per latency+1 cycles; no request overlaps another.
- Reset mid-operation: IDLE at the next edge, enables low the same cycle, response discarded. The first half of a split store is not rolled back.
- Request inputs are sampled only on accept; later changes are ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - lsu_state_e {IDLE, ACC0, ACC1, RESP};
  - size encodings SZ_BYTE=2'd0 and SZ_HALF=2'd1;
  - MEM_SZ_BYTE=4'd1 and MEM_SZ_HALF=4'd2.
- One combinational sub-module, lsu_extend: takes the assembled 16-bit result, size and signed flag, and returns rsp_rdata.
- The FSM, request latch and mem drivers stay in lsu_master.

Test Plan:
- Store halfword 0xBEEF at 0x0010, then load signed byte at 0x0011:
  - the store's ACC0 shows mem_xfer_size=2, address 0x0010, write_enable=1;
  - the load returns rsp_rdata=0xFFBE, rsp_error=0, rsp_valid 2 cycles after accept.
- Store halfword 0x1234 at 0x0021, then load halfword at 0x0021:
  - the store makes two byte writes, 0x34@0x0021 then 0x12@0x0022;
  - the load returns 0x1234 with rsp_valid 3 cycles after accept;
  - a byte load at 0x0022 with unsigned extension returns 0x0012.
- Load halfword at 0xFFFF, and separately a request with req_size=3 -> rsp_error=1 and rsp_rdata=0 one cycle after accept; both mem enables stay 0 throughout.
- Load byte 0x80 at 0x0040 with rsp_ready held low 4 cycles:
  - rsp_valid stays 1 with rsp_rdata stable, unsigned 0x0080 and signed 0xFF80;
  - req_ready stays 0 until the edge after rsp_ready rises.
- Assert reset during ACC1 of a split store of 0xAAAA at 0x0031:
  - next cycle the block is in IDLE with req_ready=1, rsp_valid=0, enables low;
  - 0x0031 holds 0xAA, and 0x0032 is unchanged.
